// File: rtl/arbiter_types.sv
// Shared types for the L1-to-pmem arbiter: FSM state encoding and datapath select values.
package arbiter_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    localparam logic ARB_SEL_I = 1'b0;
    localparam logic ARB_SEL_D = 1'b1;

endpackage

// File: rtl/arbiter_control.sv
// Control FSM that shares the physical memory port between the I-cache and D-cache,
// alternating grants on contention and routing the completion back to the owner.
module arbiter_control
    import arbiter_types::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mem_read_i,
    input  logic mem_read_d,
    input  logic mem_write_d,
    input  logic pmem_resp,
    output logic mux_sel,
    output logic pmem_read,
    output logic pmem_write,
    output logic mem_resp_i,
    output logic mem_resp_d,
    output logic busy
);

    arb_state_t state;
    logic       last_d;
    logic       op_write;
    logic       req_d;
    logic       grant_i;
    logic       grant_d;

    // On contention the requester that was not served last wins.
    assign req_d   = mem_read_d | mem_write_d;
    assign grant_i = mem_read_i & (~req_d | last_d);
    assign grant_d = req_d & (~mem_read_i | ~last_d);

    assign mem_resp_i = pmem_resp && (state == ARB_SERVE_I);
    assign mem_resp_d = pmem_resp && (state == ARB_SERVE_D);

    // Strobes and select are registered alongside the state so they are glitch-free
    // and stay frozen for the whole SERVE state, whatever the requesters do meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_d     <= 1'b1;
            op_write   <= 1'b0;
            mux_sel    <= ARB_SEL_I;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_i) begin
                        state      <= ARB_SERVE_I;
                        last_d     <= 1'b0;
                        mux_sel    <= ARB_SEL_I;
                        pmem_read  <= 1'b1;
                        pmem_write <= 1'b0;
                        busy       <= 1'b1;
                    end else if (grant_d) begin
                        state      <= ARB_SERVE_D;
                        last_d     <= 1'b1;
                        op_write   <= mem_write_d;
                        mux_sel    <= ARB_SEL_D;
                        pmem_read  <= ~mem_write_d;
                        pmem_write <= mem_write_d;
                        busy       <= 1'b1;
                    end
                end
                ARB_SERVE_I, ARB_SERVE_D: begin
                    if (pmem_resp) begin
                        state      <= ARB_IDLE;
                        mux_sel    <= ARB_SEL_I;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    mux_sel    <= ARB_SEL_I;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_control.sv
// Scoreboard bench for arbiter_control: a transaction-level model predicts grants and
// completions into queues, and a negedge monitor compares them with what the DUT presents.
module tb_arbiter_control;

    logic clk = 1'b0;
    logic rst;
    logic mem_read_i, mem_read_d, mem_write_d, pmem_resp;
    logic mux_sel, pmem_read, pmem_write, mem_resp_i, mem_resp_d, busy;

    arbiter_control dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read_i (mem_read_i),
        .mem_read_d (mem_read_d),
        .mem_write_d(mem_write_d),
        .pmem_resp  (pmem_resp),
        .mux_sel    (mux_sel),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .mem_resp_i (mem_resp_i),
        .mem_resp_d (mem_resp_d),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int   start;
        logic is_d;
        logic wr;
    } grant_t;

    grant_t     exp_q[$];
    logic [1:0] resp_q[$];
    logic [1:0] obs_sel[$];
    int         obs_cyc[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: port ownership at transaction level
    logic model_free, model_last_d, owner_d, resp_last;
    logic hold_d, rand_en, dropped_i, dropped_d, mon_en;
    int   resp_cycle, fixed_lat;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        mem_read_i  = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        pmem_resp   = 1'b0;
        exp_q.delete();
        resp_q.delete();
        model_free   = 1'b1;
        model_last_d = 1'b1;
        resp_last    = 1'b0;
        hold_d       = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Start of a cycle: retire the previous completion; the finished cache drops its request.
    task automatic tick_begin();
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        dropped_i = 1'b0;
        dropped_d = 1'b0;
        if (resp_last) begin
            resp_last  = 1'b0;
            model_free = 1'b1;
            if (owner_d) begin
                if (!hold_d) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    dropped_d   = 1'b1;
                end
            end else begin
                mem_read_i = 1'b0;
                dropped_i  = 1'b1;
            end
        end
    endtask

    // End of a cycle: with the port free, grant by alternation; otherwise maybe complete.
    task automatic tick_end();
        grant_t e;
        logic   rd;
        logic   pick_d;
        rd = mem_read_d | mem_write_d;
        if (model_free) begin
            if (mem_read_i || rd) begin
                pick_d = rd && (!mem_read_i || !model_last_d);
                e.start = cyc + 1;
                e.is_d  = pick_d;
                e.wr    = pick_d && mem_write_d;
                exp_q.push_back(e);
                model_free   = 1'b0;
                owner_d      = pick_d;
                model_last_d = pick_d;
                resp_cycle   = cyc + 1 + ((fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3)));
            end
        end else if (cyc == resp_cycle) begin
            pmem_resp = 1'b1;
            resp_q.push_back({~owner_d, owner_d});
            resp_last = 1'b1;
        end
    endtask

    task automatic apply_stimulus();
        int k;
        tick_begin();
        if (rand_en) begin
            if (!mem_read_i && !dropped_i && $urandom_range(0, 2) == 0)
                mem_read_i = 1'b1;
            if (!(mem_read_d | mem_write_d) && !dropped_d && $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, 2));
                mem_read_d  = (k != 1);
                mem_write_d = (k != 0);
            end
        end
        tick_end();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(model_free && !mem_read_i && !mem_read_d && !mem_write_d) && n < budget) begin
            apply_stimulus();
            n++;
        end
        check_output("drain_timeout", {7'd0, model_free}, 8'd1);
    endtask

    // Monitor: pops an expected grant on each strobe rise, an expected completion on each pmem_resp.
    grant_t cur;
    logic   prev_strobe = 1'b0;
    always @(negedge clk) begin
        logic strobe;
        logic [1:0] er;
        if (rst || !mon_en) begin
            prev_strobe = 1'b0;
        end else begin
            strobe = pmem_read | pmem_write;
            check_output("busy", {7'd0, busy}, {7'd0, strobe});
            if (strobe && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_grant", {6'd0, mux_sel, pmem_write}, 8'hff);
                end else begin
                    cur = exp_q.pop_front();
                    check_output("grant_cycle", 8'(cyc - cur.start), 8'd0);
                    check_output("grant_sel", {5'd0, mux_sel, pmem_write, pmem_read},
                                 {5'd0, cur.is_d, cur.wr, ~cur.wr});
                    obs_sel.push_back({mux_sel, pmem_write});
                    obs_cyc.push_back(cyc);
                end
            end else if (strobe) begin
                check_output("held_sel", {5'd0, mux_sel, pmem_write, pmem_read},
                             {5'd0, cur.is_d, cur.wr, ~cur.wr});
            end else begin
                check_output("idle_outs", {6'd0, mux_sel, pmem_write}, 8'd0);
            end
            if (pmem_resp) begin
                if (resp_q.size() == 0) begin
                    check_output("unexpected_resp", {6'd0, mem_resp_i, mem_resp_d}, 8'hff);
                end else begin
                    er = resp_q.pop_front();
                    check_output("resp_route", {6'd0, mem_resp_i, mem_resp_d}, {6'd0, er});
                end
            end else begin
                check_output("resp_quiet", {6'd0, mem_resp_i, mem_resp_d}, 8'd0);
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        int n;
        logic [1:0] exp_alt [4];
        mon_en    = 1'b0;
        rand_en   = 1'b0;
        fixed_lat = -1;
        resp_cycle = 0;
        owner_d   = 1'b0;
        dropped_i = 1'b0;
        dropped_d = 1'b0;
        do_reset();
        check_output("reset_outputs",
                     {2'd0, mux_sel, pmem_read, pmem_write, mem_resp_i, mem_resp_d, busy}, 8'd0);
        mon_en = 1'b1;

        // Reset in the middle of a D-cache write-back, then a lone I-cache read
        tick_begin();
        mem_write_d = 1'b1;
        fixed_lat   = 20;
        tick_end();
        repeat (3) apply_stimulus();
        check_output("pre_reset_write", {7'd0, pmem_write}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_reset",
                     {2'd0, mux_sel, pmem_read, pmem_write, mem_resp_i, mem_resp_d, busy}, 8'd0);
        do_reset();
        tick_begin();
        mem_read_i = 1'b1;
        fixed_lat  = 1;
        tick_end();
        wait_idle(20);

        // Lone I-cache read completing three cycles after the strobe rises
        tick_begin();
        mem_read_i = 1'b1;
        fixed_lat  = 3;
        tick_end();
        wait_idle(20);
        check_output("busy_after_i", {7'd0, busy}, 8'd0);

        // Contended I read and D write over four transactions from reset
        do_reset();
        obs_sel.delete();
        fixed_lat = -1;
        n = 0;
        while (obs_sel.size() < 4 && n < 80) begin
            tick_begin();
            if (!dropped_i) mem_read_i = 1'b1;
            if (!dropped_d) mem_write_d = 1'b1;
            tick_end();
            n++;
        end
        wait_idle(40);
        exp_alt = '{2'b00, 2'b11, 2'b00, 2'b11};
        for (int i = 0; i < 4; i++)
            check_output($sformatf("alternate_%0d", i),
                         {6'd0, (i < obs_sel.size()) ? obs_sel[i] : 2'b01}, {6'd0, exp_alt[i]});

        // Read+write at grant, write dropped mid-service
        tick_begin();
        mem_read_d  = 1'b1;
        mem_write_d = 1'b1;
        fixed_lat   = 4;
        tick_end();
        apply_stimulus();
        tick_begin();
        mem_write_d = 1'b0;
        tick_end();
        tick_begin();
        check_output("write_held", {6'd0, pmem_write, pmem_read}, 8'b10);
        tick_end();
        wait_idle(20);

        // Stray completion while idle
        tick_begin();
        tick_end();
        pmem_resp = 1'b1;
        resp_q.push_back(2'b00);
        tick_begin();
        check_output("stray_idle", {7'd0, busy}, 8'd0);
        tick_end();

        // Back-to-back D reads with the request still high in the IDLE gap
        obs_sel.delete();
        obs_cyc.delete();
        hold_d    = 1'b1;
        fixed_lat = 1;
        tick_begin();
        mem_read_d = 1'b1;
        tick_end();
        n = 0;
        while (obs_sel.size() < 2 && n < 30) begin
            apply_stimulus();
            n++;
        end
        hold_d = 1'b0;
        wait_idle(20);
        check_output("b2b_gap", 8'((obs_cyc.size() >= 2) ? (obs_cyc[1] - obs_cyc[0]) : 0), 8'd3);

        // Random traffic against the model
        fixed_lat = -1;
        rand_en   = 1'b1;
        repeat (600) apply_stimulus();
        rand_en = 1'b0;
        wait_idle(100);
        apply_stimulus();
        check_output("drain_queues", 8'(exp_q.size() + resp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
